// File: rtl/mc_cpu_pkg.sv
// Shared opcodes, FSM state encoding and decode helper for the multi-cycle
// accumulator CPU core.
package mc_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_STC = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_BEQ = 4'hC;
  localparam logic [3:0] OP_BGT = 4'hD;
  localparam logic [3:0] OP_BLT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // ALU ops are the only instructions that write C and the flags together
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational ALU: computes the C result for opcodes ADD..MUL and the
// compare flags of the current A/B operands.
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [3:0]      opcode,
  output logic [2*DW-1:0] result,
  output logic            za,
  output logic            zb,
  output logic            eq,
  output logic            gt,
  output logic            lt
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // DW+1 bit difference so its top bit is the sign of the true A-B
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = {{(DW-1){1'b0}}, sum};
      OP_SUB:  result = {{(DW-1){diff[DW]}}, diff};
      OP_AND:  result = {{DW{1'b0}}, a & b};
      OP_OR:   result = {{DW{1'b0}}, a | b};
      OP_XOR:  result = {{DW{1'b0}}, a ^ b};
      OP_MUL:  result = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      default: result = '0;
    endcase
  end

  assign za = (a == '0);
  assign zb = (b == '0);
  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle accumulator CPU core with a req/ack memory bus that may stall.
//  state    | meaning
//  S_IDLE   | parked at an instruction boundary, waiting for en
//  S_FETCH  | reading instruction at PC, held until ack
//  S_DECODE | one cycle routing on the opcode
//  S_EXEC   | ALU/LDI write C, ALU ops update flags, branches load PC
//  S_MEM    | LDA/LDB read or STC write at IR address, held until ack
//  S_HALT   | stopped; left only by reset
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [2*DW-1:0] mem_wdata,
  input  logic [2*DW-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            za,
  output logic            zb,
  output logic            eq,
  output logic            gt,
  output logic            lt,
  output logic            halted
);

  generate
    if (AW + 4 > 2 * DW) begin : g_bad_width
      $error("instruction word {opcode, addr} does not fit in 2*DW bits");
    end
  endgenerate

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   pc;
  logic [AW+3:0]   ir;
  logic [DW-1:0]   reg_a;
  logic [DW-1:0]   reg_b;
  logic [2*DW-1:0] reg_c;
  logic [3:0]      ir_op;
  logic [AW-1:0]   ir_addr;
  logic [2*DW-1:0] alu_result;
  logic            alu_za;
  logic            alu_zb;
  logic            alu_eq;
  logic            alu_gt;
  logic            alu_lt;

  assign ir_op   = ir[AW+3:AW];
  assign ir_addr = ir[AW-1:0];

  mc_cpu_alu #(
    .DW(DW)
  ) u_alu (
    .a      (reg_a),
    .b      (reg_b),
    .opcode (ir_op),
    .result (alu_result),
    .za     (alu_za),
    .zb     (alu_zb),
    .eq     (alu_eq),
    .gt     (alu_gt),
    .lt     (alu_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Bus outputs decode straight from state so reset drops mem_req at once;
  // PC and IR are frozen while a request waits, keeping address/data stable.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (ir_op)
          OP_LDA, OP_LDB, OP_STC: state_nxt = S_MEM;
          OP_HLT:                 state_nxt = S_HALT;
          default:                state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_nxt = en ? S_FETCH : S_IDLE;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = ir_addr;
        if (ir_op == OP_STC) begin
          mem_we    = 1'b1;
          mem_wdata = reg_c;
        end
        if (mem_ack) state_nxt = en ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      ir    <= '0;
      reg_a <= '0;
      reg_b <= '0;
      reg_c <= '0;
      za    <= 1'b0;
      zb    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata[AW+3:0];
            pc <= pc + AW'(1);
          end
        end
        S_EXEC: begin
          if (is_alu_op(ir_op)) begin
            reg_c <= alu_result;
            za    <= alu_za;
            zb    <= alu_zb;
            eq    <= alu_eq;
            gt    <= alu_gt;
            lt    <= alu_lt;
          end
          // branches test the flags as registered before this instruction
          case (ir_op)
            OP_LDI:  reg_c <= {{(2*DW-AW){1'b0}}, ir_addr};
            OP_JMP:  pc <= ir_addr;
            OP_BEQ:  if (eq) pc <= ir_addr;
            OP_BGT:  if (gt) pc <= ir_addr;
            OP_BLT:  if (lt) pc <= ir_addr;
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (ir_op == OP_LDA) reg_a <= mem_rdata[DW-1:0];
            if (ir_op == OP_LDB) reg_b <= mem_rdata[2*DW-1:DW];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: memory model with configurable ack delay
// and a scoreboard of expected bus transactions.
module tb_mc_cpu_core;
  import mc_cpu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          mem_ack = 1'b0;
  logic          za, zb, eq, gt, lt, halted;

  always #5 clk = ~clk;

  mc_cpu_core #(.DW(DW), .AW(AW), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .halted(halted)
  );

  // kind: 0 = instruction fetch, 1 = data read, 2 = data write
  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_e;
  logic [31:0] mem [0:4095];
  int          fetch_cyc [0:4095];
  int          ack_dly = 0, wait_cnt = 0, cyc = 0;
  int          checks = 0, errors = 0, stab_err = 0;
  logic        prev_wait = 1'b0, prev_we = 1'b0;
  logic [11:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [11:0] a);
    return {16'h0000, op, a};
  endfunction

  function automatic txn_t mk(input logic [1:0] k, input logic [11:0] a, input logic [31:0] d);
    txn_t t;
    t.kind = k; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic ef(input logic [11:0] a); exp_q.push_back(mk(2'd0, a, 32'h0)); endtask
  task automatic er(input logic [11:0] a); exp_q.push_back(mk(2'd1, a, 32'h0)); endtask
  task automatic ew(input logic [11:0] a, input logic [31:0] d); exp_q.push_back(mk(2'd2, a, d)); endtask

  // memory model: ack after ack_dly wait cycles, driven away from the active edge
  always @(negedge clk) begin
    if (mem_req && wait_cnt >= ack_dly) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  // completed transfers are popped against the scoreboard
  always @(posedge clk) begin
    cyc++;
    if (rst_n && mem_req) begin
      if (prev_wait && (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
        stab_err++;
      if (mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got we=%0b addr=%h wdata=%h, required no transfer", mem_we, mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_we !== (mon_e.kind == 2'd2) || mem_addr !== mon_e.addr ||
              (mon_e.kind == 2'd2 && mem_wdata !== mon_e.data)) begin
            errors++;
            $display("FAIL sb_txn: got we=%0b addr=%h wdata=%h, required kind=%0d addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, mon_e.kind, mon_e.addr, mon_e.data);
          end else if (mon_e.kind == 2'd0) begin
            fetch_cyc[mon_e.addr] = cyc;
          end
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
        wait_cnt  = 0;
        prev_wait = 1'b0;
      end else begin
        wait_cnt++;
        prev_wait  = 1'b1;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
      end
    end else begin
      wait_cnt  = 0;
      prev_wait = 1'b0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = ins(OP_HLT, 12'h000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    ack_dly  = 0;
    stab_err = 0;
    clear_mem();
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int max_cyc);
    for (int i = 0; i < max_cyc && halted !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic load_prog1();
    mem[0] = ins(OP_LDA, 12'h100);
    mem[1] = ins(OP_LDB, 12'h100);
    mem[2] = ins(OP_ADD, 12'h000);
    mem[3] = ins(OP_STC, 12'h101);
    mem[4] = ins(OP_HLT, 12'h000);
    mem[12'h100] = 32'h0003_0005;
    ef(0); er(12'h100); ef(1); er(12'h100); ef(2); ef(3); ew(12'h101, 32'h0000_0008); ef(4);
  endtask

  task automatic test_reset();
    int idle_req = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, mem_we, halted} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b required 000", {mem_req, mem_we, halted}); end
    checks++; if (mem_addr !== 12'h000 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h required 0", mem_addr, mem_wdata); end
    checks++; if ({za, zb, eq, gt, lt} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b required 00000", {za, zb, eq, gt, lt}); end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (mem_req !== 1'b0) idle_req++; end
    checks++; if (idle_req != 0) begin errors++; $display("FAIL idle_no_en: got %0d req cycles required 0", idle_req); end
  endtask

  task automatic test_basic();
    do_reset();
    load_prog1();
    en = 1'b1;
    wait_halt(200);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halt: got %b required 1", halted); end
    checks++; if (mem[12'h101] !== 32'h0000_0008) begin errors++; $display("FAIL basic_store: got %h required 00000008", mem[12'h101]); end
    checks++; if ({za, zb, eq, gt, lt} !== 5'b00010) begin errors++; $display("FAIL basic_flags: got %b required 00010", {za, zb, eq, gt, lt}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_sb_left: got %0d pending required 0", exp_q.size()); end
    checks++; if (fetch_cyc[2] - fetch_cyc[1] != 3) begin errors++; $display("FAIL basic_ld_lat: got %0d required 3", fetch_cyc[2] - fetch_cyc[1]); end
    checks++; if (fetch_cyc[3] - fetch_cyc[2] != 3) begin errors++; $display("FAIL basic_alu_lat: got %0d required 3", fetch_cyc[3] - fetch_cyc[2]); end
    checks++; if (fetch_cyc[4] - fetch_cyc[3] != 3) begin errors++; $display("FAIL basic_st_lat: got %0d required 3", fetch_cyc[4] - fetch_cyc[3]); end
  endtask

  task automatic test_alu_edges();
    do_reset();
    mem[0] = ins(OP_LDA, 12'h100);
    mem[1] = ins(OP_LDB, 12'h100);
    mem[2] = ins(OP_ADD, 12'h000);
    mem[3] = ins(OP_STC, 12'h101);
    mem[4] = ins(OP_SUB, 12'h000);
    mem[5] = ins(OP_STC, 12'h102);
    mem[6] = ins(OP_MUL, 12'h000);
    mem[7] = ins(OP_STC, 12'h103);
    mem[8] = ins(OP_HLT, 12'h000);
    mem[12'h100] = 32'h0001_FFFF;
    ef(0); er(12'h100); ef(1); er(12'h100); ef(2); ef(3); ew(12'h101, 32'h0001_0000);
    ef(4); ef(5); ew(12'h102, 32'h0000_FFFE); ef(6); ef(7); ew(12'h103, 32'h0000_FFFF); ef(8);
    en = 1'b1;
    wait_halt(300);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL alu_halt: got %b required 1", halted); end
    checks++; if (mem[12'h101] !== 32'h0001_0000) begin errors++; $display("FAIL alu_add_carry: got %h required 00010000", mem[12'h101]); end
    checks++; if (mem[12'h102] !== 32'h0000_FFFE) begin errors++; $display("FAIL alu_sub: got %h required 0000fffe", mem[12'h102]); end
    checks++; if (mem[12'h103] !== 32'h0000_FFFF) begin errors++; $display("FAIL alu_mul: got %h required 0000ffff", mem[12'h103]); end
    checks++; if ({za, zb, eq, gt, lt} !== 5'b00010) begin errors++; $display("FAIL alu_flags: got %b required 00010", {za, zb, eq, gt, lt}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL alu_sb_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_branch();
    do_reset();
    mem[0] = ins(OP_LDA, 12'h100);
    mem[1] = ins(OP_LDB, 12'h100);
    mem[2] = ins(OP_SUB, 12'h000);
    mem[3] = ins(OP_BEQ, 12'h020);
    mem[12'h020] = ins(OP_LDA, 12'h101);
    mem[12'h021] = ins(OP_LDB, 12'h101);
    mem[12'h022] = ins(OP_SUB, 12'h000);
    mem[12'h023] = ins(OP_BEQ, 12'h030);
    mem[12'h024] = ins(OP_BLT, 12'h040);
    mem[12'h040] = ins(OP_STC, 12'h102);
    mem[12'h100] = 32'h0007_0007;
    mem[12'h101] = 32'h0008_0007;
    ef(0); er(12'h100); ef(1); er(12'h100); ef(2); ef(3);
    ef(12'h020); er(12'h101); ef(12'h021); er(12'h101); ef(12'h022); ef(12'h023); ef(12'h024);
    ef(12'h040); ew(12'h102, 32'hFFFF_FFFF); ef(12'h041);
    en = 1'b1;
    wait_halt(300);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL br_halt: got %b required 1", halted); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL br_sb_left: got %0d pending required 0", exp_q.size()); end
    checks++; if (fetch_cyc[12'h020] - fetch_cyc[3] != 3) begin errors++; $display("FAIL br_taken_lat: got %0d required 3", fetch_cyc[12'h020] - fetch_cyc[3]); end
    checks++; if ({za, zb, eq, gt, lt} !== 5'b00001) begin errors++; $display("FAIL br_flags: got %b required 00001", {za, zb, eq, gt, lt}); end
    checks++; if (mem[12'h102] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL br_sub_neg: got %h required ffffffff", mem[12'h102]); end
  endtask

  task automatic test_wait_states();
    do_reset();
    ack_dly = 3;
    load_prog1();
    en = 1'b1;
    wait_halt(400);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ws_halt: got %b required 1", halted); end
    checks++; if (mem[12'h101] !== 32'h0000_0008) begin errors++; $display("FAIL ws_store: got %h required 00000008", mem[12'h101]); end
    checks++; if ({eq, gt, lt} !== 3'b010) begin errors++; $display("FAIL ws_flags: got %b required 010", {eq, gt, lt}); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL ws_stable: got %0d changes required 0", stab_err); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ws_sb_left: got %0d pending required 0", exp_q.size()); end
    checks++; if (fetch_cyc[3] - fetch_cyc[2] != 6) begin errors++; $display("FAIL ws_alu_lat: got %0d required 6", fetch_cyc[3] - fetch_cyc[2]); end
  endtask

  task automatic test_en_park();
    bit hit = 0;
    int park_req = 0;
    do_reset();
    ack_dly = 2;
    mem[0] = ins(OP_LDA, 12'h100);
    mem[1] = ins(OP_LDB, 12'h100);
    mem[2] = ins(OP_SUB, 12'h000);
    mem[3] = ins(OP_STC, 12'h101);
    mem[4] = ins(OP_HLT, 12'h000);
    mem[12'h100] = 32'h0004_0009;
    ef(0); er(12'h100); ef(1); er(12'h100); ef(2); ef(3); ew(12'h101, 32'h0000_0005); ef(4);
    en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 12'h100) begin hit = 1; break; end
    end
    en = 1'b0;
    checks++; if (hit != 1) begin errors++; $display("FAIL park_find_mem: got %0d required 1 (timeout)", hit); end
    repeat (4) @(negedge clk);
    repeat (8) begin @(negedge clk); if (mem_req !== 1'b0) park_req++; end
    checks++; if (park_req != 0) begin errors++; $display("FAIL park_idle: got %0d req cycles required 0", park_req); end
    checks++; if (exp_q.size() != 6) begin errors++; $display("FAIL park_sb_pos: got %0d pending required 6", exp_q.size()); end
    en = 1'b1;
    wait_halt(300);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL park_halt: got %b required 1", halted); end
    checks++; if (mem[12'h101] !== 32'h0000_0005) begin errors++; $display("FAIL park_store: got %h required 00000005", mem[12'h101]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL park_sb_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    do_reset();
    ack_dly = 3;
    mem[0] = ins(OP_LDA, 12'h100);
    mem[1] = ins(OP_ADD, 12'h000);
    mem[2] = ins(OP_NOP, 12'h000);
    mem[12'h100] = 32'h0000_0003;
    ef(0); er(12'h100); ef(1);
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gt === 1'b1 && mem_req === 1'b1 && mem_addr === 12'h002) begin hit = 1; break; end
    end
    checks++; if (hit != 1) begin errors++; $display("FAIL rmid_find_fetch: got %0d required 1 (timeout)", hit); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_drop: got %b required 0", mem_req); end
    checks++; if ({za, zb, eq, gt, lt, halted} !== 6'b0) begin errors++; $display("FAIL rmid_flags: got %b required 000000", {za, zb, eq, gt, lt, halted}); end
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_sb_left: got %0d pending required 0", exp_q.size()); end
    exp_q.delete();
    ack_dly = 0;
    clear_mem();
    mem[0]       = ins(OP_BEQ, 12'h010);
    mem[1]       = ins(OP_JMP, 12'hFFF);
    mem[12'hFFF] = ins(OP_ADD, 12'h000);
    mem[12'h010] = ins(OP_LDI, 12'h0AB);
    mem[12'h011] = ins(OP_STC, 12'h200);
    ef(0); ef(1); ef(12'hFFF); ef(0); ef(12'h010); ef(12'h011); ew(12'h200, 32'h0000_00AB); ef(12'h012);
    rst_n = 1'b1;
    en    = 1'b1;
    wait_halt(300);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wrap_halt: got %b required 1", halted); end
    checks++; if (mem[12'h200] !== 32'h0000_00AB) begin errors++; $display("FAIL wrap_ldi: got %h required 000000ab", mem[12'h200]); end
    checks++; if ({za, zb, eq, gt, lt} !== 5'b11100) begin errors++; $display("FAIL wrap_flags: got %b required 11100", {za, zb, eq, gt, lt}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_sb_left: got %0d pending required 0", exp_q.size()); end
    checks++; if (fetch_cyc[0] - fetch_cyc[12'hFFF] != 3) begin errors++; $display("FAIL wrap_lat: got %0d required 3", fetch_cyc[0] - fetch_cyc[12'hFFF]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu_edges();
    test_branch();
    test_wait_states();
    test_en_park();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
